// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and helpers for the fifo put arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Ceiling log2, usable in parameter expressions; also used by fifo_controller.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin request picker, searching from the slot after last_id
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_id_i,
    output logic [NUM_REQ-1:0] pick_onehot_o,
    output logic [IDX_W-1:0]   pick_id_o,
    output logic               any_valid_o
);

    // rot_idx[k] is the producer examined k-th in this round's search order.
    logic [IDX_W-1:0] rot_idx [NUM_REQ];

    always_comb begin
        int pos;
        pos = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(last_id_i) + 1 + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            rot_idx[k] = IDX_W'(pos);
        end
    end

    // Walk from the back so the earliest position in the search order wins.
    always_comb begin
        pick_onehot_o = '0;
        pick_id_o     = '0;
        any_valid_o   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[rot_idx[k]]) begin
                pick_onehot_o              = '0;
                pick_onehot_o[rot_idx[k]]  = 1'b1;
                pick_id_o                  = rot_idx[k];
                any_valid_o                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_put_arbiter.sv
// rtl/fifo_put_arbiter.sv - round-robin, burst-limited sharing of one FIFO put port
module fifo_put_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int GRANT_W    = clog2(NUM_REQ)
) (
    input  logic                          in_clock,
    input  logic                          in_reset_n,
    input  logic [NUM_REQ-1:0]            in_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic                          in_fifo_full,
    output logic [NUM_REQ-1:0]            out_ack,
    output logic                          out_put,
    output logic [DATA_WIDTH-1:0]         out_put_data,
    output logic [GRANT_W-1:0]            out_grant_id,
    output logic                          out_busy
);

    localparam int                 BEAT_W        = clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT     = BEAT_W'(MAX_BURST - 1);
    localparam logic [GRANT_W-1:0] RESET_LAST_ID = GRANT_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_id_q, grant_id_d;
    logic [GRANT_W-1:0] last_id_q, last_id_d;
    logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [GRANT_W-1:0] pick_id;
    logic               pick_valid;

    logic                  owner_req;
    logic                  put;
    logic [DATA_WIDTH-1:0] data_mux;

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req_i        (in_req),
        .last_id_i    (last_id_q),
        .pick_onehot_o(pick_onehot),
        .pick_id_o    (pick_id),
        .any_valid_o  (pick_valid)
    );

    // grant_oh_q is non-zero only while a producer owns the port.
    assign owner_req = |(in_req & grant_oh_q);
    assign put       = (state_q == ST_OWN) && owner_req && !in_fifo_full;

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh_q[i]) begin
                data_mux = data_mux | in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        last_id_d  = last_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_OWN;
                    grant_id_d = pick_id;
                    grant_oh_d = pick_onehot;
                    beat_cnt_d = '0;
                end
            end
            ST_OWN: begin
                // A stalled owner withdrawing its request releases without a put.
                if (!owner_req || (put && (beat_cnt_q == LAST_BEAT))) begin
                    state_d    = ST_IDLE;
                    last_id_d  = grant_id_q;
                    grant_oh_d = '0;
                    beat_cnt_d = '0;
                end else if (put) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            last_id_q  <= RESET_LAST_ID;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            last_id_q  <= last_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign out_put      = put;
    assign out_ack      = grant_oh_q & {NUM_REQ{put}};
    assign out_put_data = data_mux;
    assign out_grant_id = grant_id_q;
    assign out_busy     = (state_q == ST_OWN);

    ack_onehot_a: assert property (@(posedge in_clock) disable iff (!in_reset_n)
        $onehot0(out_ack));
    no_put_when_full_a: assert property (@(posedge in_clock) disable iff (!in_reset_n)
        !(out_put && in_fifo_full));

endmodule

// File: tb/tb_fifo_put_arbiter.sv
// tb/tb_fifo_put_arbiter.sv - scoreboard bench for fifo_put_arbiter with a 16-entry FIFO model
module tb_fifo_put_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int GW    = 2;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           full;
    logic [N-1:0]   ack;
    logic           put;
    logic [W-1:0]   put_data;
    logic [GW-1:0]  gid;
    logic           busy;

    always #5 clk = ~clk;

    fifo_put_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(W),
        .MAX_BURST (4)
    ) dut (
        .in_clock    (clk),
        .in_reset_n  (rst_n),
        .in_req      (req),
        .in_data     (data),
        .in_fifo_full(full),
        .out_ack     (ack),
        .out_put     (put),
        .out_put_data(put_data),
        .out_grant_id(gid),
        .out_busy    (busy)
    );

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rem[N];
    int   seq[N];
    int   exp_seq[N];
    int   fifo_cnt;
    int   cyc;
    int   order[4] = '{0, 1, 3, 0};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic void drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i]          = (rem[i] > 0);
            data[i*W +: W]  = W'(i * 64 + (seq[i] % 64));
        end
        full = (fifo_cnt >= DEPTH);
    endfunction

    task automatic push_exp(input int id, input int c);
        exp_t e;
        e.id   = id;
        e.data = W'(id * 64 + (exp_seq[id] % 64));
        e.cyc  = c;
        exp_seq[id]++;
        sb.push_back(e);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            rem[i]     = 0;
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        fifo_cnt = 0;
        sb.delete();
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One clock: sample at negedge, then apply effects of the edge just after posedge.
    task automatic step(input int take);
        exp_t         e;
        logic         put_s;
        logic [N-1:0] ack_s;
        @(negedge clk);
        put_s = put;
        ack_s = ack;
        if (put) begin
            check_val("put_while_full", full, 0);
            if (sb.size() == 0) begin
                check_val("unexpected_put", put, 0);
            end else begin
                e = sb.pop_front();
                check_val("put_id", gid, e.id);
                check_val("put_data", put_data, e.data);
                check_val("ack_onehot", ack, 1 << e.id);
                if (e.cyc >= 0) check_val("put_cycle", cyc, e.cyc);
            end
        end else begin
            check_val("ack_without_put", ack, 0);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (put_s) fifo_cnt++;
        for (int i = 0; i < N; i++) begin
            if (ack_s[i] && rem[i] > 0) begin
                rem[i]--;
                seq[i]++;
            end
        end
        if (take > 0 && fifo_cnt > 0) fifo_cnt--;
        drive_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // Reset with every producer requesting
        clear_model();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_put", put, 0);
        check_val("rst_ack", ack, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_gid", gid, 0);
        check_val("rst_data", put_data, 0);
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < N; k++) push_exp(k, 1 + 3 * k);
        repeat (12) step(0);
        check_val("t1_drain", sb.size(), 0);

        // Single producer, six entries
        do_reset();
        rem[2] = 6;
        drive_inputs();
        for (int k = 0; k < 6; k++) push_exp(2, 1 + 5 * (k / 4) + (k % 4));
        repeat (10) step(0);
        check_val("t2_drain", sb.size(), 0);
        check_val("t2_fifo_cnt", fifo_cnt, 6);

        // Round robin across producers 0,1,3
        do_reset();
        rem[0] = 8; rem[1] = 4; rem[3] = 4;
        drive_inputs();
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++) push_exp(order[b], 1 + 5 * b + j);
        repeat (22) step(0);
        check_val("t3_drain", sb.size(), 0);

        // Full stall: beat count must freeze while full
        do_reset();
        rem[0] = 20;
        drive_inputs();
        for (int k = 0; k < 16; k++) push_exp(0, 1 + 5 * (k / 4) + (k % 4));
        for (int k = 0; k < 4; k++) push_exp(0, -1);
        repeat (21) step(0);
        #1;
        check_val("t4_stall_busy", busy, 1);
        check_val("t4_stall_put", put, 0);
        check_val("t4_stall_ack", ack, 0);
        repeat (2) step(0);
        #1;
        check_val("t4_stall_put2", put, 0);
        for (int t = 0; t < 4; t++) begin
            step(1);
            #1;
            check_val("t4_take_put", put, 1);
            check_val("t4_take_ack", ack, 1);
            step(0);
            #1;
            check_val("t4_refull_put", put, 0);
            check_val("t4_burst_busy", busy, (t < 3) ? 1 : 0);
            step(0);
        end
        check_val("t4_drain", sb.size(), 0);

        // Stalled owner drops its request
        do_reset();
        rem[0] = 16;
        drive_inputs();
        for (int k = 0; k < 16; k++) push_exp(0, 1 + 5 * (k / 4) + (k % 4));
        repeat (20) step(0);
        rem[1] = 5; rem[2] = 2;
        push_exp(2, -1);
        push_exp(2, -1);
        drive_inputs();
        step(0);
        #1;
        check_val("t5_grant1_busy", busy, 1);
        check_val("t5_grant1_id", gid, 1);
        check_val("t5_grant1_put", put, 0);
        rem[1] = 0;
        drive_inputs();
        step(0);
        #1;
        check_val("t5_release_busy", busy, 0);
        step(0);
        #1;
        check_val("t5_grant2_busy", busy, 1);
        check_val("t5_grant2_id", gid, 2);
        repeat (6) step(1);
        check_val("t5_drain", sb.size(), 0);
        check_val("t5_rem2", rem[2], 0);

        // Reset after two puts of a burst
        do_reset();
        rem[0] = 4;
        drive_inputs();
        push_exp(0, 1);
        push_exp(0, 2);
        push_exp(0, -1);
        push_exp(0, -1);
        repeat (3) step(0);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_put", put, 0);
        check_val("t6_rst_ack", ack, 0);
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_data", put_data, 0);
        check_val("t6_fifo_cnt", fifo_cnt, 2);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        repeat (6) step(0);
        check_val("t6_drain", sb.size(), 0);
        check_val("t6_fifo_cnt_end", fifo_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
